// File: rtl/pooler_2d.sv
// pooler_2d: streaming non-overlapping KxK max/average pooler over an IMG_W x IMG_W raster.
// Optional feature macro POOLER_AVG_EN adds the per-frame average mode; without it the block is max-only.
module pooler_2d #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 12,
  parameter int K      = 2
) (
  input  logic              clk,
  input  logic              master_rst,
  input  logic              ce,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_op,
  output logic              end_op
);

  localparam int LOG2K = $clog2(K);
  localparam int SHIFT = 2 * LOG2K;
  localparam int NW    = IMG_W / K;
  localparam int CNT_W = $clog2(IMG_W);
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
`ifdef POOLER_AVG_EN
  localparam int BUF_W = DATA_W + SHIFT;
`else
  localparam int BUF_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(IMG_W - 1);
  localparam logic [LOG2K-1:0] SUB_LAST = '1;

  logic [CNT_W-1:0]        r_col;
  logic [CNT_W-1:0]        r_row;
  logic signed [BUF_W-1:0] r_buf [NW];

  logic [IDX_W-1:0]        w_idx;
  logic                    w_first;
  logic                    w_last;
  logic                    w_origin;
  logic                    w_frame_end;
  logic signed [BUF_W-1:0] w_pix;
  logic signed [BUF_W-1:0] w_entry;
  logic signed [BUF_W-1:0] w_max;
  logic signed [BUF_W-1:0] w_comb;
  logic [DATA_W-1:0]       w_result;

  assign w_idx       = IDX_W'(r_col >> LOG2K);
  assign w_first     = (r_row[LOG2K-1:0] == '0) && (r_col[LOG2K-1:0] == '0);
  assign w_last      = (r_row[LOG2K-1:0] == SUB_LAST) && (r_col[LOG2K-1:0] == SUB_LAST);
  assign w_origin    = (r_row == '0) && (r_col == '0);
  assign w_frame_end = (r_row == LAST_POS) && (r_col == LAST_POS);

  // Pixels are always held sign-extended so max and sum share one buffer format.
  assign w_pix   = BUF_W'($signed(data_in));
  assign w_entry = r_buf[w_idx];
  assign w_max   = (w_pix > w_entry) ? w_pix : w_entry;

`ifdef POOLER_AVG_EN
  logic                    r_mode_q;
  logic signed [BUF_W-1:0] w_sum;

  assign w_sum    = w_entry + w_pix;
  assign w_comb   = r_mode_q ? w_sum : w_max;
  // Arithmetic shift gives floor division; the quotient always fits in DATA_W.
  assign w_result = r_mode_q ? DATA_W'(w_sum >>> SHIFT) : DATA_W'(w_max);

  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      r_mode_q <= 1'b0;
    end else if (ce && w_origin) begin
      r_mode_q <= mode;
    end
  end
`else
  logic w_mode_unused;

  assign w_mode_unused = mode;
  assign w_comb        = w_max;
  assign w_result      = DATA_W'(w_max);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      r_col    <= '0;
      r_row    <= '0;
      data_out <= '0;
      valid_op <= 1'b0;
      end_op   <= 1'b0;
    end else begin
      valid_op <= 1'b0;
      end_op   <= 1'b0;
      if (ce) begin
        if (r_col == LAST_POS) begin
          r_col <= '0;
          r_row <= (r_row == LAST_POS) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_last) begin
          data_out <= w_result;
          valid_op <= 1'b1;
          end_op   <= w_frame_end;
        end
      end
    end
  end

  // NOTE: the partial-result buffer has no reset; each entry is overwritten by the first pixel of its window.
  always_ff @(posedge clk) begin
    if (ce) begin
      r_buf[w_idx] <= w_first ? w_pix : w_comb;
    end
  end

endmodule

// File: doc/pooler_2d.md
# pooler_2d

Parametrised streaming 2-D pooling stage for the CNN accelerator datapath. It sits between a convolution/activation stage and the next layer. It accepts one signed pixel per enabled cycle in raster order and emits one pooled value per non-overlapping K×K window, either max or average. It generalises the fixed 12×12, 2×2, 32-bit max pooler to configurable word width, image width and kernel size, and adds a per-frame average mode.

## Interface
Parameters:
- DATA_W, 32, pixel width; two's-complement signed.
- IMG_W, 12, image width and height in pixels. Must be a multiple of K.
- K, 2, window size and stride. Must be a power of two, 2..8.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- master_rst  in  1  asynchronous, active-low reset. Asserted at 0, released synchronously by the upstream reset tree.
- ce  in  1  input qualifier; data_in is consumed on each rising edge with ce=1.
- mode  in  1  0 = max, 1 = average. Sampled only on the first pixel of a frame.
- data_in  in  DATA_W  input pixel.
- data_out  out  DATA_W  pooled result.
- valid_op  out  1  one-cycle pulse; data_out is valid.
- end_op  out  1  one-cycle pulse coincident with the last valid_op of a frame.

## Operation
- Counters:
  - col (0..IMG_W-1) and row (0..IMG_W-1) advance only on ce=1.
  - col wraps to 0 and increments row.
  - After (IMG_W-1, IMG_W-1), both wrap to 0 and the next pixel starts a new frame. There is no idle gap.
- Partial-result buffer: IMG_W/K entries of ACC_W = DATA_W + 2·log2(K) bits, indexed by col/K. Implemented as registers.
- Per accepted pixel at (row, col), with w = col/K:
  - First pixel of a window (row%K==0 and col%K==0): entry[w] <= data_in, sign-extended in average mode.
  - Otherwise: entry[w] <= max(entry[w], data_in) or entry[w] + data_in.
  - Last pixel of a window (row%K==K-1 and col%K==K-1): the combined result is registered to data_out and valid_op pulses.
- Max compares signed.
- Average is the arithmetic right shift of the full sum by 2·log2(K), which is floor division. The result is truncated to DATA_W and cannot overflow.
- mode_q is captured when (row, col) = (0, 0) is accepted and holds for the whole frame. Mode changes mid-frame are ignored.
- end_op = valid_op on the window at (IMG_W-1, IMG_W-1).
- Outputs per frame: (IMG_W/K)², in raster order of windows.

## Timing
- Reset values:
  - data_out = 0, valid_op = 0, end_op = 0, row = col = 0, mode_q = 0.
  - Buffer entries are don't-care; each is overwritten on the first pixel of its window.
- Latency: valid_op is asserted in the cycle after the edge that accepts the window's last pixel. One registered stage.
- valid_op and end_op are high for exactly one cycle. data_out holds its value until the next valid_op.
- ce=0: all state holds and no outputs pulse. A ce gap inside a window does not change the result.
- No backpressure. The downstream stage must accept data_out on every valid_op.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronous).
  - The partial frame is discarded.
  - The first pixel accepted after release is (0, 0) of a new frame, and mode is re-sampled there.
- Back-to-back frames: the end_op of frame n may coincide with acceptance of pixel (0, 0) of frame n+1. Both are handled in the same cycle.

## Configuration
- POOLER_AVG_EN defined:
  - Average mode and the adder path are present.
  - Buffer width is ACC_W.
- Not defined:
  - mode is ignored, the block is max-only, and mode_q is tied to 0.
  - Buffer width is DATA_W and no adder is synthesised.
  - Max-mode results and timing are identical to the build with the macro defined.

## Test plan
- Max ramp, defaults, mode=0, data_in = 0..143 with ce=1 every cycle:
  - 36 valid_op pulses; first data_out = 13, then 15, 17, 19, 21, 23.
  - Second output row starts at 37; last output = 143 with end_op=1.
  - Each valid_op arrives one cycle after pixels 13, 15, ….
- Average ramp, POOLER_AVG_EN, mode=1, data_in = 0..143:
  - First output = 6 ((0+1+12+13)>>2 = 26>>2).
  - Last output = 136 ((130+131+142+143)>>2 = 546>>2).
- Signed window, first window = {-3, -5, -1, -7}:
  - max -> -1.
  - avg -> -4 (-16>>2).
  - Window {-1, 0, 0, 0}: avg -> -1 (floor, not truncation toward zero).
- ce gaps: ramp 0..143 with ce deasserted for 1–3 random cycles between pixels.
  - Same 36 values as the max ramp; valid_op always one cycle after the accepting edge; no pulses during ce=0.
- Mid-frame reset: assert master_rst=0 after pixel 50, release, then stream 0..143.
  - Outputs are 0 during reset.
  - The next 36 outputs match the clean max ramp, and end_op fires once.
- Mode latch and back-to-back frames: stream two frames without a gap; mode=1 at frame-1 start, toggled mid-frame, mode=0 at frame-2 start.
  - Frame 1 is all averages, frame 2 all maxima.
  - end_op is asserted exactly twice; parameter sweep repeated with IMG_W=16, K=4, DATA_W=16.
